// File: rtl/ram_pkg.sv
// Shared definitions for the bus-attached RAM: FSM encoding, word geometry
// and the upper bound on programmable wait states.
package ram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned WCNT_W          = 4;

endpackage

// File: rtl/ram_byte_array.sv
// Single-port, read-first word array with per-byte write enables and a
// registered read port; shaped so synthesis maps it onto block RAM.
module ram_byte_array
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter string       INIT_FILE   = "",
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // The read samples the old word in the same edge the lanes are written.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ram_bus_slave.sv
// PicoRV32 native-bus RAM slave: accepts a request in IDLE, optionally
// stalls for WAIT_STATES cycles, then pulses mem_ready for one cycle.
module ram_bus_slave
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  mem_err
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);

  generate
    if (DEPTH_WORDS > (2 ** IDX_W)) begin : g_depth_chk
      $fatal(1, "ram_bus_slave: DEPTH_WORDS exceeds the decoded address space");
    end
    if (WAIT_STATES > WAIT_STATES_MAX) begin : g_wait_chk
      $fatal(1, "ram_bus_slave: WAIT_STATES out of range");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              accept;
  logic              err_q;
  logic              rd_ok_q;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              arr_en;
  logic [31:0]       arr_rdata;
  logic              unused_addr_bits;

  assign idx              = mem_addr[ADDR_WIDTH-1:2];
  assign in_range         = {1'b0, idx} < DEPTH_L;
  assign unused_addr_bits = ^mem_addr[1:0];
  assign arr_en           = accept && in_range && !rst;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WCNT_W'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_RESP;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        err_q   <= !in_range;
        rd_ok_q <= in_range;
      end
    end
  end

  // The array output register has no reset and does not update on
  // out-of-range accesses, so it is masked to zero in those cases.
  assign mem_ready = (state_q == S_RESP);
  assign mem_rdata = rd_ok_q ? arr_rdata : '0;
  assign mem_err   = err_q;

  ram_byte_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (mem_wstrb),
    .addr  (idx[AW-1:0]),
    .wdata (mem_wdata),
    .rdata (arr_rdata)
  );

endmodule
